// File: rtl/seg7_scan_rotator.sv
// seg7_scan_rotator
// Scan and rotation controller for a 4-digit 7-segment display.
// It holds four 3-bit character codes and lights one digit at a time.
// It outputs the code of the lit digit to the downstream decoder.
// Every ROT_FRAMES complete frames, the char-to-position mapping rotates by one place.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_BLANK | no valid characters yet, display dark, accepting loads
//  ST_RUN   | scanning digits, accepting loads
//  ST_PEND  | scanning old characters, new set buffered until frame end
module seg7_scan_rotator #(
    parameter int SCAN_DIV   = 4,   // clocks each digit slot is lit (>=2)
    parameter int ROT_FRAMES = 2    // full frames per rotation step (>=1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [11:0] load_data,
    output logic        load_ready,
    input  logic        rot_en,
    input  logic        rot_dir,
    output logic [3:0]  an,
    output logic [2:0]  char_out,
    output logic [1:0]  digit_idx,
    output logic [1:0]  sel,
    output logic        frame_tick
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(ROT_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_RUN   = 2'd1,
        ST_PEND  = 2'd2
    } state_t;

    state_t        r_state;
    logic [2:0]    r_char [4];
    logic [11:0]   r_buf;
    logic [DW-1:0] r_div;
    logic [1:0]    r_digit;
    logic [1:0]    r_sel;
    logic [FW-1:0] r_fcnt;

    state_t        w_state_nxt;
    logic [2:0]    w_char_nxt [4];
    logic [11:0]   w_buf_nxt;
    logic [DW-1:0] w_div_nxt;
    logic [1:0]    w_digit_nxt;
    logic [1:0]    w_sel_nxt;
    logic [FW-1:0] w_fcnt_nxt;

    logic          w_scanning;
    logic          w_boundary;
    logic          w_handshake;
    logic [1:0]    w_pos;

    // Status decoded from registered state only, so outputs never see inputs combinationally
    assign w_scanning  = (r_state != ST_BLANK);
    assign w_boundary  = w_scanning && (r_digit == 2'd3) && (r_div == DIV_LAST);
    assign load_ready  = (r_state != ST_PEND);
    assign w_handshake = load_valid && load_ready;
    assign w_pos       = r_digit + r_sel;

    // Display outputs: one-hot-low anode, rotated character, scan position
    always_comb begin
        an         = 4'b1111;
        char_out   = 3'd0;
        if (w_scanning) begin
            an       = ~(4'b0001 << r_digit);
            char_out = r_char[w_pos];
        end
        digit_idx  = r_digit;
        sel        = r_sel;
        frame_tick = w_boundary;
    end

    // Next-state logic: scan timing, rotation, and load acceptance or deferral
    always_comb begin
        w_state_nxt = r_state;
        w_char_nxt  = r_char;
        w_buf_nxt   = r_buf;
        w_div_nxt   = r_div;
        w_digit_nxt = r_digit;
        w_sel_nxt   = r_sel;
        w_fcnt_nxt  = r_fcnt;

        case (r_state)
            ST_BLANK: begin
                if (w_handshake) begin
                    for (int i = 0; i < 4; i++) begin
                        w_char_nxt[i] = load_data[3*i +: 3];
                    end
                    w_state_nxt = ST_RUN;
                    w_div_nxt   = '0;
                    w_digit_nxt = 2'd0;
                    w_sel_nxt   = 2'd0;
                    w_fcnt_nxt  = '0;
                end
            end

            ST_RUN, ST_PEND: begin
                if (r_div == DIV_LAST) begin
                    w_div_nxt   = '0;
                    w_digit_nxt = r_digit + 2'd1;
                end else begin
                    w_div_nxt   = r_div + DW'(1);
                end

                if (!rot_en) begin
                    w_fcnt_nxt = '0;
                end else if (w_boundary) begin
                    if (r_fcnt == FRM_LAST) begin
                        w_fcnt_nxt = '0;
                        w_sel_nxt  = rot_dir ? (r_sel - 2'd1) : (r_sel + 2'd1);
                    end else begin
                        w_fcnt_nxt = r_fcnt + FW'(1);
                    end
                end

                // A load landing on a frame boundary overrides any rotation step due then
                if (w_boundary && ((r_state == ST_PEND) || w_handshake)) begin
                    for (int i = 0; i < 4; i++) begin
                        w_char_nxt[i] = (r_state == ST_PEND) ? r_buf[3*i +: 3]
                                                             : load_data[3*i +: 3];
                    end
                    w_sel_nxt   = 2'd0;
                    w_fcnt_nxt  = '0;
                    w_state_nxt = ST_RUN;
                end else if ((r_state == ST_RUN) && w_handshake) begin
                    w_buf_nxt   = load_data;
                    w_state_nxt = ST_PEND;
                end
            end

            default: begin
                w_state_nxt = ST_BLANK;
            end
        endcase
    end

    // State register with synchronous reset; reset also discards any buffered load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BLANK;
            for (int i = 0; i < 4; i++) begin
                r_char[i] <= 3'd0;
            end
            r_buf   <= 12'd0;
            r_div   <= '0;
            r_digit <= 2'd0;
            r_sel   <= 2'd0;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_char  <= w_char_nxt;
            r_buf   <= w_buf_nxt;
            r_div   <= w_div_nxt;
            r_digit <= w_digit_nxt;
            r_sel   <= w_sel_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_rotator.sv
// Testbench for seg7_scan_rotator: directed scenarios plus a randomized phase.
// Every cycle's outputs are checked against a frame-position reference model.
module tb_seg7_scan_rotator;

    localparam int SD = 4;
    localparam int RF = 2;
    localparam int FL = 4 * SD;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [11:0] load_data;
    logic        load_ready;
    logic        rot_en;
    logic        rot_dir;
    logic [3:0]  an;
    logic [2:0]  char_out;
    logic [1:0]  digit_idx;
    logic [1:0]  sel;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg7_scan_rotator #(.SCAN_DIV(SD), .ROT_FRAMES(RF)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .rot_en     (rot_en),
        .rot_dir    (rot_dir),
        .an         (an),
        .char_out   (char_out),
        .digit_idx  (digit_idx),
        .sel        (sel),
        .frame_tick (frame_tick)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: position within the frame, shown chars, offset, frame count
    bit          m_active;
    bit          m_pend;
    logic [11:0] m_pbuf;
    int          m_chars [4];
    int          m_t;
    int          m_sel;
    int          m_frames;

    task automatic model_reset();
        m_active = 0;
        m_pend   = 0;
        m_pbuf   = '0;
        for (int i = 0; i < 4; i++) m_chars[i] = 0;
        m_t      = 0;
        m_sel    = 0;
        m_frames = 0;
    endtask

    task automatic model_set_chars(input logic [11:0] d);
        for (int i = 0; i < 4; i++) m_chars[i] = int'(d[3*i +: 3]);
    endtask

    task automatic model_step(input bit rst, input bit lv, input logic [11:0] d,
                              input bit re, input bit rd);
        bit bnd;
        bit hs;
        if (rst) begin
            model_reset();
        end else if (!m_active) begin
            if (lv) begin
                model_set_chars(d);
                m_active = 1;
                m_t      = 0;
                m_sel    = 0;
                m_frames = 0;
            end
        end else begin
            bnd = (m_t == FL - 1);
            hs  = lv && !m_pend;
            if (bnd && (hs || m_pend)) begin
                model_set_chars(m_pend ? m_pbuf : d);
                m_pend   = 0;
                m_sel    = 0;
                m_frames = 0;
                m_t      = 0;
            end else begin
                if (hs) begin
                    m_pbuf = d;
                    m_pend = 1;
                end
                if (!re) begin
                    m_frames = 0;
                end else if (bnd) begin
                    m_frames++;
                    if (m_frames == RF) begin
                        m_frames = 0;
                        m_sel    = rd ? (m_sel + 3) % 4 : (m_sel + 1) % 4;
                    end
                end
                m_t = (m_t + 1) % FL;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int         dig;
        logic [3:0] e_an;
        int         e_char;
        dig    = m_active ? (m_t / SD) : 0;
        e_an   = 4'hF;
        e_char = 0;
        if (m_active) begin
            e_an[dig] = 1'b0;
            e_char    = m_chars[(dig + m_sel) % 4];
        end
        chk("an",         16'(an),         16'(e_an));
        chk("char_out",   16'(char_out),   16'(e_char));
        chk("digit_idx",  16'(digit_idx),  16'(dig));
        chk("sel",        16'(sel),        16'(m_sel));
        chk("frame_tick", 16'(frame_tick), 16'(m_active && (m_t == FL - 1)));
        chk("load_ready", 16'(load_ready), 16'(!m_pend));
    endtask

    // One clock: check registered outputs mid-cycle, then drive inputs for the next edge
    task automatic cyc(input bit rst, input bit lv, input logic [11:0] d,
                       input bit re, input bit rd);
        @(negedge clk);
        check_outputs();
        reset      = rst;
        load_valid = lv;
        load_data  = d;
        rot_en     = re;
        rot_dir    = rd;
        model_step(rst, lv, d, re, rd);
    endtask

    initial begin
        bit          seen_nonzero;
        bit          r_re;
        bit          r_rd;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        rot_en     = 1'b0;
        rot_dir    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // 1: reset held, then idle in BLANK
        cyc(1, 0, 12'd0, 0, 0);
        cyc(1, 0, 12'd0, 0, 0);
        repeat (5) cyc(0, 0, 12'd0, 0, 0);

        // 2: load from BLANK, scan three frames without rotation
        cyc(0, 1, 12'o3210, 0, 0);
        repeat (3 * FL) cyc(0, 0, 12'd0, 0, 0);

        // 3: rotate forward through a full wrap, then backward from offset 0
        seen_nonzero = 0;
        for (int k = 0; k < 400; k++) begin
            if (m_sel != 0) seen_nonzero = 1;
            if (seen_nonzero && m_sel == 0) break;
            cyc(0, 0, 12'd0, 1, 0);
        end
        chk("wrap_to_zero", 16'(seen_nonzero && m_sel == 0), 16'd1);
        repeat (3 * FL) cyc(0, 0, 12'd0, 1, 1);

        // 4: load mid-frame at digit 1; further offers while pending are ignored
        for (int k = 0; k < 2 * FL && m_t != SD + 1; k++) cyc(0, 0, 12'd0, 0, 0);
        cyc(0, 1, 12'o7654, 0, 0);
        repeat (3) cyc(0, 1, 12'o1111, 0, 0);
        repeat (FL + 4) cyc(0, 0, 12'd0, 0, 0);

        // 5: load exactly on the boundary where a rotation step is due
        for (int k = 0; k < 4 * FL && !(m_t == FL - 1 && m_frames == RF - 1); k++)
            cyc(0, 0, 12'd0, 1, 0);
        chk("step_due", 16'(m_t == FL - 1 && m_frames == RF - 1), 16'd1);
        cyc(0, 1, 12'o0123, 1, 0);
        repeat (FL + 4) cyc(0, 0, 12'd0, 1, 0);

        // 6: reset while a load is pending
        for (int k = 0; k < 2 * FL && m_t != 3; k++) cyc(0, 0, 12'd0, 0, 0);
        cyc(0, 1, 12'o5555, 0, 0);
        repeat (2) cyc(0, 0, 12'd0, 0, 0);
        cyc(1, 0, 12'd0, 0, 0);
        repeat (2 * FL) cyc(0, 0, 12'd0, 0, 0);

        // Randomized traffic: sparse loads, slowly changing rotation controls, rare resets
        r_re = 1;
        r_rd = 0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 49) == 0) r_re = ~r_re;
            if ($urandom_range(0, 29) == 0) r_rd = ~r_rd;
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 11) == 0),
                12'($urandom),
                r_re, r_rd);
        end
        cyc(0, 0, 12'd0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
